// File: rtl/axis_counter_sequencer_if.sv
// Config, trigger and status signals between the register block, the sequencer and the counter.
// Unclocked bundle; the sequencer registers every output it drives.
interface axis_counter_sequencer_if #(
  parameter int CNTR_WIDTH = 32,
  parameter int NTRG_WIDTH = 16
);
  logic                  cfg_start;
  logic                  cfg_stop;
  logic                  cfg_ext_en;
  logic [CNTR_WIDTH-1:0] cfg_delay;
  logic [CNTR_WIDTH-1:0] cfg_period;
  logic [NTRG_WIDTH-1:0] cfg_ntrg;
  logic                  ext_trg;
  logic                  run_flag;
  logic                  trg_flag;
  logic                  sts_busy;
  logic                  sts_done;
  logic [NTRG_WIDTH-1:0] sts_trg_cnt;

  modport master (
    output cfg_start, cfg_stop, cfg_ext_en, cfg_delay, cfg_period, cfg_ntrg, ext_trg,
    input  run_flag, trg_flag, sts_busy, sts_done, sts_trg_cnt
  );

  modport slave (
    input  cfg_start, cfg_stop, cfg_ext_en, cfg_delay, cfg_period, cfg_ntrg, ext_trg,
    output run_flag, trg_flag, sts_busy, sts_done, sts_trg_cnt
  );
endinterface

// File: rtl/axis_counter_sequencer.sv
// Run/trigger sequencer: turns start/stop commands into run_flag and counted trg_flag pulses.
// All outputs registered; start or stop -> outputs one cycle later; external trigger -> pulse one cycle later.
module axis_counter_sequencer #(
  parameter int CNTR_WIDTH = 32,
  parameter int NTRG_WIDTH = 16
) (
  input logic                        aclk,
  input logic                        areset,
  axis_counter_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, DELAY, ACTIVE, DONE} state_t;

  state_t                state_q, state_d;
  logic                  start_prev, ext_prev;
  logic                  start_edge, ext_edge;
  logic [CNTR_WIDTH-1:0] dly_q, dly_d;
  logic [CNTR_WIDTH-1:0] per_q, per_d;
  logic [CNTR_WIDTH-1:0] per_m1_q, per_m1_d;
  logic [NTRG_WIDTH-1:0] ntrg_q, ntrg_d;
  logic                  ext_en_q, ext_en_d;
  logic [NTRG_WIDTH-1:0] cnt_q, cnt_d;
  logic                  run_q, run_d;
  logic                  trg_q, trg_d;
  logic                  done_q, done_d;
  logic                  last_trg;

  assign start_edge = bus.cfg_start & ~start_prev;
  assign ext_edge   = bus.ext_trg & ~ext_prev;
  // The pulse currently on trg_flag completed the programmed count.
  assign last_trg   = trg_q && (ntrg_q != '0) && (cnt_q == ntrg_q);

  always_comb begin
    state_d  = state_q;
    dly_d    = dly_q;
    per_d    = per_q;
    per_m1_d = per_m1_q;
    ntrg_d   = ntrg_q;
    ext_en_d = ext_en_q;
    cnt_d    = cnt_q;
    trg_d    = 1'b0;
    done_d   = done_q;

    case (state_q)
      IDLE, DONE: begin
        if (start_edge) begin
          state_d  = DELAY;
          dly_d    = (bus.cfg_delay == '0) ? '0 : bus.cfg_delay - 1'b1;
          per_m1_d = (bus.cfg_period == '0) ? '0 : bus.cfg_period - 1'b1;
          ntrg_d   = bus.cfg_ntrg;
          ext_en_d = bus.cfg_ext_en;
          cnt_d    = '0;
          done_d   = 1'b0;
        end
      end
      DELAY: begin
        if (dly_q == '0) begin
          state_d = ACTIVE;
          per_d   = per_m1_q;
          if (!ext_en_q) begin
            trg_d = 1'b1;
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          dly_d = dly_q - 1'b1;
        end
      end
      ACTIVE: begin
        if (last_trg) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (ext_en_q) begin
          if (ext_edge) begin
            trg_d = 1'b1;
            cnt_d = cnt_q + 1'b1;
          end
        end else if (per_q == '0) begin
          trg_d = 1'b1;
          cnt_d = cnt_q + 1'b1;
          per_d = per_m1_q;
        end else begin
          per_d = per_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Stop overrides start, trigger and completion alike; the count is kept for status.
    if (bus.cfg_stop) begin
      state_d = IDLE;
      trg_d   = 1'b0;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
    end

    run_d = (state_d == DELAY) || (state_d == ACTIVE);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= IDLE;
      start_prev <= 1'b1;
      ext_prev   <= 1'b1;
      dly_q      <= '0;
      per_q      <= '0;
      per_m1_q   <= '0;
      ntrg_q     <= '0;
      ext_en_q   <= 1'b0;
      cnt_q      <= '0;
      run_q      <= 1'b0;
      trg_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_prev <= bus.cfg_start;
      ext_prev   <= bus.ext_trg;
      dly_q      <= dly_d;
      per_q      <= per_d;
      per_m1_q   <= per_m1_d;
      ntrg_q     <= ntrg_d;
      ext_en_q   <= ext_en_d;
      cnt_q      <= cnt_d;
      run_q      <= run_d;
      trg_q      <= trg_d;
      done_q     <= done_d;
    end
  end

  assign bus.run_flag    = run_q;
  assign bus.sts_busy    = run_q;
  assign bus.trg_flag    = trg_q;
  assign bus.sts_done    = done_q;
  assign bus.sts_trg_cnt = cnt_q;

endmodule

// File: tb/tb_axis_counter_sequencer.sv
// Bench for axis_counter_sequencer: directed and random runs against a trigger-schedule model.
module tb_axis_counter_sequencer;
  localparam int CW   = 32;
  localparam int NW   = 4;
  localparam int MAXC = 64;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  axis_counter_sequencer_if #(.CNTR_WIDTH(CW), .NTRG_WIDTH(NW)) bus ();
  axis_counter_sequencer #(.CNTR_WIDTH(CW), .NTRG_WIDTH(NW)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [7:0] obs  [MAXC];
  logic [7:0] expv [MAXC];
  bit         edge_map [MAXC];
  bit         last_fin = 1'b1;

  // {busy, run, trg, done, cnt}
  function automatic logic [7:0] pack_out();
    return {bus.sts_busy, bus.run_flag, bus.trg_flag, bus.sts_done, bus.sts_trg_cnt};
  endfunction

  task automatic clear_edges();
    for (int i = 0; i < MAXC; i++) edge_map[i] = 1'b0;
  endtask

  // Expected outputs per cycle relative to R, derived from the trigger schedule rules.
  task automatic model(input int d, input int p, input int n, input bit ext, input int nc);
    int de, pe, last, cnt, pi;
    bit trg;
    logic [NW-1:0] c4;
    int pulses[$];
    de = (d == 0) ? 1 : d;
    pe = (p == 0) ? 1 : p;
    if (!ext) begin
      for (int k = 0; (n == 0 || k < n) && (de + k * pe) < nc; k++) pulses.push_back(de + k * pe);
    end else begin
      for (int e = de; e < MAXC; e++)
        if (edge_map[e] && (n == 0 || pulses.size() < n)) pulses.push_back(e + 1);
    end
    last = (n != 0 && pulses.size() == n) ? pulses[n-1] : MAXC + 100;
    cnt = 0;
    pi  = 0;
    for (int c = 0; c < nc; c++) begin
      trg = 1'b0;
      if (pi < pulses.size() && pulses[pi] == c) begin
        trg = 1'b1;
        cnt++;
        pi++;
      end
      c4 = cnt[NW-1:0];
      expv[c] = {(c <= last), (c <= last), trg, (c > last), c4};
    end
    last_fin = (last < nc);
  endtask

  // Stops any unfinished run, issues a start edge (cycle N), then records cycles R..R+nc-1.
  task automatic drive_run(input int d, input int p, input int n, input bit ext, input int nc);
    if (!last_fin) begin
      @(posedge aclk); #1;
      bus.cfg_stop  = 1'b1;
      bus.cfg_start = 1'b0;
      bus.ext_trg   = 1'b0;
    end
    @(posedge aclk); #1;
    bus.cfg_stop   = 1'b0;
    bus.cfg_start  = 1'b1;
    bus.ext_trg    = 1'b0;
    bus.cfg_delay  = d;
    bus.cfg_period = p;
    bus.cfg_ntrg   = n[NW-1:0];
    bus.cfg_ext_en = ext;
    model(d, p, n, ext, nc);
    for (int i = 0; i < nc; i++) begin
      @(posedge aclk); #1;
      bus.cfg_start = 1'b0;
      bus.ext_trg   = edge_map[i];
      if (i == 1) begin
        bus.cfg_delay  = $urandom_range(0, 9);
        bus.cfg_period = $urandom_range(0, 9);
        bus.cfg_ntrg   = NW'($urandom_range(0, 15));
        bus.cfg_ext_en = ($urandom_range(0, 1) == 1);
      end
      @(negedge aclk);
      obs[i] = pack_out();
    end
  endtask

  task automatic test_reset();
    logic [7:0] o;
    bus.cfg_start = 1'b1;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    o = pack_out();
    n_chk++;
    if (o !== 8'h00) begin n_fail++; $display("FAIL reset_state: got %b want %b", o, 8'h00); end
    areset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      o = pack_out();
      n_chk++;
      if (o !== 8'h00) begin n_fail++; $display("FAIL start_high_at_release cyc %0d: got %b want %b", i, o, 8'h00); end
    end
    @(posedge aclk); #1;
    bus.cfg_start = 1'b0;
    clear_edges();
    drive_run(1, 1, 1, 0, 4);
    for (int c = 0; c < 4; c++) begin
      n_chk++;
      if (obs[c] !== expv[c]) begin n_fail++; $display("FAIL first_start R+%0d: got %b want %b", c, obs[c], expv[c]); end
    end
  endtask

  task automatic test_internal();
    clear_edges();
    drive_run(5, 10, 3, 0, 30);
    for (int c = 0; c < 30; c++) begin
      n_chk++;
      if (obs[c] !== expv[c]) begin n_fail++; $display("FAIL internal R+%0d: got %b want %b", c, obs[c], expv[c]); end
    end
  endtask

  task automatic test_min_values();
    clear_edges();
    drive_run(0, 0, 4, 0, 8);
    for (int c = 0; c < 8; c++) begin
      n_chk++;
      if (obs[c] !== expv[c]) begin n_fail++; $display("FAIL min_values R+%0d: got %b want %b", c, obs[c], expv[c]); end
    end
  endtask

  task automatic test_external();
    clear_edges();
    edge_map[1] = 1'b1; edge_map[4] = 1'b1; edge_map[8] = 1'b1; edge_map[12] = 1'b1;
    drive_run(3, 7, 2, 1, 16);
    for (int c = 0; c < 16; c++) begin
      n_chk++;
      if (obs[c] !== expv[c]) begin n_fail++; $display("FAIL external R+%0d: got %b want %b", c, obs[c], expv[c]); end
    end
  endtask

  task automatic test_wrap();
    clear_edges();
    drive_run(1, 2, 0, 0, 40);
    for (int c = 0; c < 40; c++) begin
      n_chk++;
      if (obs[c] !== expv[c]) begin n_fail++; $display("FAIL wrap R+%0d: got %b want %b", c, obs[c], expv[c]); end
    end
  endtask

  task automatic test_stop();
    logic [7:0] o;
    clear_edges();
    drive_run(2, 3, 0, 0, 6);
    for (int c = 0; c < 6; c++) begin
      n_chk++;
      if (obs[c] !== expv[c]) begin n_fail++; $display("FAIL stop_prerun R+%0d: got %b want %b", c, obs[c], expv[c]); end
    end
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    bus.cfg_stop  = 1'b1;
    bus.cfg_start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge aclk); #1;
      bus.cfg_stop = 1'b0;
      @(negedge aclk);
      o = pack_out();
      n_chk++;
      if (o !== 8'h02) begin n_fail++; $display("FAIL stop_clears cyc %0d: got %b want %b", i, o, 8'h02); end
    end
    @(posedge aclk); #1;
    bus.cfg_start = 1'b0;
    last_fin = 1'b1;
    drive_run(1, 2, 3, 0, 10);
    for (int c = 0; c < 10; c++) begin
      n_chk++;
      if (obs[c] !== expv[c]) begin n_fail++; $display("FAIL stop_restart R+%0d: got %b want %b", c, obs[c], expv[c]); end
    end
  endtask

  task automatic test_reset_midrun();
    logic [7:0] o;
    clear_edges();
    drive_run(2, 3, 0, 0, 8);
    for (int c = 0; c < 8; c++) begin
      n_chk++;
      if (obs[c] !== expv[c]) begin n_fail++; $display("FAIL midrun_prerun R+%0d: got %b want %b", c, obs[c], expv[c]); end
    end
    #2;
    areset = 1'b1;
    #1;
    o = pack_out();
    n_chk++;
    if (o !== 8'h00) begin n_fail++; $display("FAIL async_reset_immediate: got %b want %b", o, 8'h00); end
    @(posedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    last_fin = 1'b1;
    @(negedge aclk);
    o = pack_out();
    n_chk++;
    if (o !== 8'h00) begin n_fail++; $display("FAIL after_midrun_reset: got %b want %b", o, 8'h00); end
  endtask

  task automatic test_random();
    int d, p, n, nc, e;
    bit ext;
    for (int it = 0; it < 8; it++) begin
      d   = $urandom_range(0, 6);
      p   = $urandom_range(0, 5);
      n   = $urandom_range(0, 5);
      ext = ($urandom_range(0, 1) == 1);
      clear_edges();
      if (ext) begin
        nc = 56;
        e  = $urandom_range(0, 3);
        while (e < nc - 1) begin
          edge_map[e] = 1'b1;
          e += $urandom_range(2, 5);
        end
      end else begin
        nc = ((d == 0) ? 1 : d) + ((n == 0) ? 3 : n) * ((p == 0) ? 1 : p) + 4;
      end
      drive_run(d, p, n, ext, nc);
      for (int c = 0; c < nc; c++) begin
        n_chk++;
        if (obs[c] !== expv[c]) begin
          n_fail++;
          $display("FAIL random it%0d d=%0d p=%0d n=%0d ext=%0b R+%0d: got %b want %b", it, d, p, n, ext, c, obs[c], expv[c]);
        end
      end
    end
  endtask

  initial begin
    bus.cfg_start  = 1'b0;
    bus.cfg_stop   = 1'b0;
    bus.cfg_ext_en = 1'b0;
    bus.cfg_delay  = '0;
    bus.cfg_period = '0;
    bus.cfg_ntrg   = '0;
    bus.ext_trg    = 1'b0;
    test_reset();
    test_internal();
    test_min_values();
    test_external();
    test_wrap();
    test_stop();
    test_reset_midrun();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule

// File: doc/axis_counter_sequencer.md
# axis_counter_sequencer

Run/trigger sequencer for the free-running AXI-Stream sample counter. It turns configuration-register commands into the `run_flag` level and `trg_flag` pulses the counter consumes. It issues a programmable number of triggers, either on an internal period or gated from an external trigger, after a programmable hold-off from run start. It sits between the AXI config/status register block and the counter core; status goes back to the status register.

## Interface
Parameters:
- `CNTR_WIDTH`, 32, width of the delay and period counters and their config ports
- `NTRG_WIDTH`, 16, width of the trigger-count config and status

Ports:
- `aclk`  in  1  system clock
- `areset`  in  1  asynchronous, active-high reset
- `cfg_start`  in  1  a rising edge (low then high) starts a run
- `cfg_stop`  in  1  level; aborts any run
- `cfg_ext_en`  in  1  1 = triggers come from `ext_trg`, 0 = internal period
- `cfg_delay`  in  CNTR_WIDTH  hold-off cycles from run start to trigger enable
- `cfg_period`  in  CNTR_WIDTH  internal trigger interval in cycles
- `cfg_ntrg`  in  NTRG_WIDTH  triggers per run; 0 = unlimited
- `ext_trg`  in  1  external trigger, synchronous to `aclk`; rising edge is active
- `run_flag`  out  1  to the counter; high while a run is active
- `trg_flag`  out  1  to the counter; one-cycle trigger pulse
- `sts_busy`  out  1  state is DELAY or ACTIVE
- `sts_done`  out  1  the run completed `cfg_ntrg` triggers
- `sts_trg_cnt`  out  NTRG_WIDTH  triggers issued in the current or last run

## Operation
- States: IDLE, DELAY, ACTIVE, DONE.
- All outputs are registered.
- Reset: state IDLE; `run_flag`, `trg_flag`, `sts_busy`, `sts_done` = 0; `sts_trg_cnt` = 0.
  - The `cfg_start` and `ext_trg` edge-detect history registers reset to 1, so a level already high at reset release is not an edge.
- Start: on a `cfg_start` edge in IDLE or DONE, latch `cfg_delay`, `cfg_period`, `cfg_ntrg`, `cfg_ext_en`.
  - Clear `sts_trg_cnt` and `sts_done`, then go to DELAY.
  - A start edge in DELAY or ACTIVE is ignored.
  - Config changes mid-run have no effect.
- Effective values: delay_eff = max(cfg_delay, 1); period_eff = max(cfg_period, 1).
- DELAY: count delay_eff cycles, then go to ACTIVE. `ext_trg` edges in DELAY are ignored.
- ACTIVE, internal mode: first `trg_flag` on entry to ACTIVE, then one every period_eff cycles.
- ACTIVE, external mode: each `ext_trg` rising edge gives a `trg_flag` pulse on the next cycle.
- Each pulse increments `sts_trg_cnt`.
  - With `cfg_ntrg` = 0 the count wraps modulo 2^NTRG_WIDTH and the run never ends.
- Completion: with `cfg_ntrg` ≠ 0, the cycle after the pulse that makes `sts_trg_cnt` = `cfg_ntrg`:
  - state DONE, `run_flag` = 0, `sts_busy` = 0, `sts_done` = 1.
- Stop: `cfg_stop` high in any state forces IDLE the next cycle.
  - `run_flag` = `trg_flag` = `sts_busy` = `sts_done` = 0; `sts_trg_cnt` is held.
  - Stop has priority over a simultaneous start edge, trigger or completion.
- `areset` mid-run returns the block to the reset state at once (asynchronous).

## Timing
- Start edge sampled at cycle N → `run_flag` = 1 and `sts_busy` = 1 at N+1 (call this R).
- First internal trigger at R + delay_eff. `trg_flag` is never high in the first cycle `run_flag` is high, because the counter needs `run_flag` registered before it sees a trigger.
- Internal triggers at R + delay_eff + k·period_eff, for k = 0..ntrg−1.
  - period_eff = 1 gives `trg_flag` high on consecutive cycles.
- External mode: latency from `ext_trg` edge to `trg_flag` is 1 cycle.
  - The earliest counted edge is the one sampled at R + delay_eff.
- Last pulse at cycle T → `run_flag` = 0 and `sts_done` = 1 at T+1.
- `sts_trg_cnt` updates in the same cycle `trg_flag` is high.
- `cfg_stop` sampled at N → outputs cleared at N+1.

## Test plan
- Reset, then start with delay=5, period=10, ntrg=3, internal mode → `run_flag` rises at R; `trg_flag` pulses at R+5, R+15, R+25; `run_flag`=0 and `sts_done`=1 at R+26; `sts_trg_cnt`=3.
- delay=0, period=0, ntrg=4 → pulses at R+1, R+2, R+3, R+4 (effective delay and period both 1); `sts_done` at R+5.
- External mode, delay=3, ntrg=2; `ext_trg` edges at R+1, R+4, R+8, R+12 → R+1 edge ignored; pulses at R+5 and R+9; done at R+10; the R+12 edge has no effect.
- ntrg=0, period=2, NTRG_WIDTH=4, run for 40 cycles → `sts_trg_cnt` wraps 15→0; `run_flag` stays high; `sts_done` stays 0.
- Mid-run `cfg_stop` asserted in the same cycle as a scheduled trigger and a start edge → no `trg_flag`; IDLE next cycle; count held; a later start edge restarts with count 0.
- `cfg_start` held high through `areset` release, then `areset` pulsed mid-ACTIVE → no run starts until `cfg_start` goes low then high; the mid-run reset clears all outputs immediately, without waiting for a clock edge.
